// File: rtl/pixel_sink.sv
// pixel_sink: buffers plotted pixels through a small FIFO into a 160x120x3 shadow
// framebuffer and answers colour queries once every earlier pixel has landed.
module pixel_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       ready,
    input  logic       query_valid,
    input  logic [7:0] query_x,
    input  logic [6:0] query_y,
    output logic [2:0] query_colour,
    output logic       query_done,
    output logic       busy,
    output logic [7:0] drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PIXELS = X_MAX * Y_MAX;
    localparam logic [14:0] LAST_ADDR = 15'(PIXELS - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, FLUSH, READ, DONE} state_t;
    state_t state, state_next;

    logic [17:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        accept, push, pop, pix_ok, q_ok, q_oor;
    logic [14:0] clear_addr, q_addr, ram_wa;
    logic [2:0]  ram [PIXELS];
    logic [2:0]  ram_rd, ram_wd;
    logic        ram_we;

    // y*160 + x without a multiplier; callers guarantee the coordinate is on screen
    function automatic logic [14:0] pix_index(input logic [7:0] px, input logic [6:0] py);
        return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
    endfunction

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_ok     = 32'(x) < X_MAX && 32'(y) < Y_MAX;
    assign q_ok       = 32'(query_x) < X_MAX && 32'(query_y) < Y_MAX;
    assign accept     = plot && ready;
    assign push       = accept && pix_ok;
    assign pop        = (state == IDLE || state == FLUSH) && !fifo_empty;

    always_ff @(posedge clock)
        state <= reset ? CLEAR : state_next;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   state_next = clear_addr == LAST_ADDR ? IDLE : CLEAR;
            IDLE:    state_next = query_valid ? FLUSH : IDLE;
            FLUSH:   state_next = fifo_empty ? READ : FLUSH;
            READ:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        ready = state == IDLE && !fifo_full;
        busy  = state != IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            clear_addr   <= '0;
            drop_count   <= '0;
            query_done   <= 1'b0;
            query_colour <= 3'b000;
            q_addr       <= '0;
            q_oor        <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (state == CLEAR)
                clear_addr <= clear_addr + 15'd1;
            if (accept && !pix_ok && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
            // an off-screen query parks the read on address 0 and is masked to black later
            if (state == IDLE && query_valid) begin
                q_addr <= q_ok ? pix_index(query_x, query_y) : '0;
                q_oor  <= !q_ok;
            end
            query_done <= state == DONE;
            if (state == DONE)
                query_colour <= q_oor ? 3'b000 : ram_rd;
        end
    end

    always_ff @(posedge clock)
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {pix_index(x, y), colour};

    always_comb begin
        ram_we = state == CLEAR || pop;
        ram_wa = state == CLEAR ? clear_addr : fifo_mem[rd_ptr[AW-1:0]][17:3];
        ram_wd = state == CLEAR ? 3'b000 : fifo_mem[rd_ptr[AW-1:0]][2:0];
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            ram[ram_wa] <= ram_wd;
        ram_rd <= ram[q_addr];
    end
endmodule

// File: doc/pixel_sink.md
# pixel_sink

Receiving end of the (x, y, colour, plot) pixel stream produced by the drawing FSMs (bird, hunter, laser). Buffers accepted pixel writes in a small FIFO and commits them to an on-chip 160x120x3 shadow framebuffer that mirrors what the VGA adapter displays. Provides a query port that returns the colour at a coordinate, so hit detection can read back what was drawn.

## Interface
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, at least 2.
- X_MAX, 160, screen width; x >= X_MAX is out of range.
- Y_MAX, 120, screen height; y >= Y_MAX is out of range.

- clock  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- x  in  8  pixel column.
- y  in  7  pixel row.
- colour  in  3  pixel colour {R,G,B}.
- plot  in  1  write request; a pixel is accepted on an edge where plot && ready.
- ready  out  1  sink can accept a pixel this cycle.
- query_valid  in  1  read request; sampled only in IDLE.
- query_x  in  8  query column; captured with query_valid.
- query_y  in  7  query row; captured with query_valid.
- query_colour  out  3  colour read back; holds until the next query_done.
- query_done  out  1  one-cycle pulse; query_colour is valid.
- busy  out  1  high in any state other than IDLE.
- drop_count  out  8  saturating count of accepted out-of-range pixels.

## Operation
- Address is y*160 + x, computed as (y<<7)+(y<<5)+x on 15 bits. No wrap: out-of-range coordinates never produce an address.
- States:
  - CLEAR: writes 3'b000 to addresses 0..19199, one per cycle, then goes to IDLE.
  - IDLE: accepts pixels and queries.
  - FLUSH: waits for the FIFO to empty.
  - READ: presents the query address to the RAM.
  - DONE: latches the RAM data and pulses query_done.
- Transitions:
  - Reset goes to CLEAR from any state.
  - CLEAR goes to IDLE after address 19199 is written.
  - IDLE goes to FLUSH on query_valid.
  - FLUSH goes to READ when the FIFO is empty.
  - READ goes to DONE.
  - DONE goes to IDLE.
- ready = (state == IDLE) && !fifo_full. Pixels are not accepted during CLEAR, FLUSH, READ or DONE.
- Out-of-range pixels (x >= X_MAX or y >= Y_MAX) are still accepted (handshake completes). They are not pushed to the FIFO, and drop_count increments, saturating at 255.
- Drain: in IDLE and FLUSH, when the FIFO is non-empty, pop one entry per cycle and write it to RAM.
- Ordering: a query observes every pixel accepted on or before the edge on which it was sampled, including a pixel accepted on the same edge.
- An out-of-range query skips the RAM read and returns 3'b000. It keeps the same latency.
- Simultaneous push and pop when full: not possible, because ready is low when the FIFO is full.
- query_valid outside IDLE is ignored; the requester holds it until busy is low.

## Timing
- Reset values:
  - ready = 0, busy = 1, query_done = 0, query_colour = 3'b000, drop_count = 0.
  - FIFO empty, state CLEAR.
- Reset asserted mid-operation discards FIFO contents and any in-flight query; no query_done pulse is produced.
- CLEAR lasts 19200 cycles after reset deasserts. ready rises on the following cycle.
- Pixel accepted at edge N is written to RAM at edge N+1 at the earliest, plus one cycle per entry ahead of it in the FIFO.
- Query with an empty FIFO: query_valid sampled at edge E. FLUSH spans one cycle, then READ, then DONE. query_done is high in the cycle after edge E+3.
- Each FIFO entry pending at E adds one cycle of latency. A pixel accepted on edge E counts as pending.
- RAM has a synchronous read with 1-cycle latency. query_colour is registered.
- query_done is high for exactly one cycle.

## Test plan
- Reset, then idle: ready = 0 for 19200 cycles, then ready = 1. A query at (0,0) and a query at (159,119) both return 3'b000.
- Plot (5,7,3'b111), then query (5,7) two cycles later: query_done arrives 3 cycles after the query with query_colour = 3'b111.
- Hold plot for 20 consecutive in-range pixels while issuing a query on the 10th acceptance edge:
  - ready drops the cycle after the query is sampled.
  - query latency = 3 + pending count.
  - The queried pixel, written in the 10th acceptance, reads back correctly.
  - Plotting resumes once busy falls.
- Plot x = 160 and y = 120 pixels 300 times: drop_count saturates at 255, and no RAM address changes (spot-query (0,0) returns 3'b000).
- Fill the FIFO during FLUSH stall conditions: ready stays 0 while full or not IDLE, and no pixel is lost. Re-query every written coordinate and confirm its colour.
- Assert reset while a query is in FLUSH: no query_done pulse. CLEAR restarts, and after CLEAR all previously drawn pixels read 3'b000.
